// File: rtl/slurm_mem_pkg.sv
// slurm_mem_pkg: shared memory-side widths and read-initiator channel indices
package slurm_mem_pkg;
  localparam int DEF_ADDR_BITS = 16;
  localparam int DEF_DATA_BITS = 16;
  localparam int CH_SPRITE = 0;
  localparam int CH_BG0 = 1;
  localparam int CH_BG1 = 2;
  localparam int CH_AUDIO = 3;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first request at or after ptr wins
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  logic [PW-1:0] c;
  assign any = |req;
  // scan from farthest to nearest so the channel closest to ptr is written last
  always_comb begin
    gnt = '0;
    idx = '0;
    c = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = PW'((int'(ptr) + k) % N);
      if (req[c]) idx = c;
    end
    gnt[idx] = any;
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin read responder with alternating-fairness CPU write port
module memory_arbiter
  import slurm_mem_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [CHANNELS*ADDR_BITS-1:0] ch_address,
  input  logic [CHANNELS-1:0]           ch_rvalid,
  output logic [CHANNELS-1:0]           ch_rready,
  output logic [DATA_BITS-1:0]          ch_data,
  input  logic [ADDR_BITS-1:0]          wr_address,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [ADDR_BITS-1:0]          mem_address,
  output logic                          mem_wr,
  output logic [DATA_BITS-1:0]          mem_wr_data,
  input  logic [DATA_BITS-1:0]          mem_rd_data
);
  localparam int PW = $clog2(CHANNELS);
  logic                 pend_valid, last_was_write, any_rd, do_wr, do_rd, ret;
  logic [PW-1:0]        pend_ch, rr_ptr, idx;
  logic [CHANNELS-1:0]  elig, gnt;
  logic [ADDR_BITS-1:0] rd_addr;
  rr_arbiter #(.N(CHANNELS)) u_rr (
    .req(elig),
    .ptr(rr_ptr),
    .gnt(gnt),
    .idx(idx),
    .any(any_rd)
  );
  // the return slot and any new grant are suppressed while reset is held
  assign ret = pend_valid && !RST;
  assign ch_rready = ret ? CHANNELS'(1) << pend_ch : '0;
  assign ch_data = ret ? mem_rd_data : '0;
  assign elig = ch_rvalid & ~ch_rready;
  assign do_wr = !RST && wr_valid && !(last_was_write && any_rd);
  assign do_rd = !RST && !do_wr && any_rd;
  assign wr_ready = do_wr;
  assign mem_wr = do_wr;
  assign mem_wr_data = do_wr ? wr_data : '0;
  assign mem_address = do_wr ? wr_address : do_rd ? rd_addr : '0;
  // one-hot grant selects the winning channel's address
  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < CHANNELS; i++)
      if (gnt[i]) rd_addr = ch_address[i*ADDR_BITS +: ADDR_BITS];
  end
  // pipeline state: pending return, write-fairness history, round-robin pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_valid <= 1'b0;
      pend_ch <= '0;
      last_was_write <= 1'b0;
      rr_ptr <= '0;
    end else begin
      pend_valid <= do_rd;
      pend_ch <= idx;
      last_was_write <= do_wr;
      if (do_rd) rr_ptr <= idx == PW'(CHANNELS - 1) ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed checks of arbitration, pipelined returns, write fairness and reset
module tb_memory_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] ch_address;
  logic [3:0]  ch_rvalid;
  logic [3:0]  ch_rready;
  logic [15:0] ch_data;
  logic [15:0] wr_address;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] mem_address;
  logic        mem_wr;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data;
  logic [15:0] sram [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;
  int checks = 0;
  int failures = 0;

  memory_arbiter dut (
    .CLK(CLK),
    .RST(RST),
    .ch_address(ch_address),
    .ch_rvalid(ch_rvalid),
    .ch_rready(ch_rready),
    .ch_data(ch_data),
    .wr_address(wr_address),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .mem_address(mem_address),
    .mem_wr(mem_wr),
    .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 CLK = ~CLK;

  // synchronous-read SRAM with a bench-side preload port
  always @(posedge CLK) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    else if (mem_wr) sram[mem_address] <= mem_wr_data;
    mem_rd_data <= sram[mem_address];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic quiet_reset();
    RST = 1'b1;
    ch_rvalid = '0;
    wr_valid = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    wr_valid = 1'b1;
    wr_address = 16'h0055;
    wr_data = 16'h00AA;
    ch_rvalid = 4'b1111;
    ch_address = {16'h4, 16'h3, 16'h2, 16'h1};
    tick();
    tick();
    #1;
    checks++; if (ch_rready !== 4'b0) begin failures++; $display("FAIL reset_rready got=%b exp=0000", ch_rready); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL reset_wr_ready got=%b exp=0", wr_ready); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
    checks++; if (mem_address !== 16'h0) begin failures++; $display("FAIL reset_mem_address got=%h exp=0000", mem_address); end
    checks++; if (ch_data !== 16'h0) begin failures++; $display("FAIL reset_ch_data got=%h exp=0000", ch_data); end
    ch_rvalid = '0;
    wr_valid = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    RST = 1'b1;
    preload(16'h0100, 16'hBEEF);
    quiet_reset();
    ch_address[15:0] = 16'h0100;
    ch_rvalid = 4'b0001;
    #1;
    checks++; if (mem_address !== 16'h0100) begin failures++; $display("FAIL single_grant_addr got=%h exp=0100", mem_address); end
    checks++; if (ch_rready !== 4'b0000) begin failures++; $display("FAIL single_no_early_rready got=%b exp=0000", ch_rready); end
    tick();
    checks++; if (ch_rready !== 4'b0001) begin failures++; $display("FAIL single_rready got=%b exp=0001", ch_rready); end
    checks++; if (ch_data !== 16'hBEEF) begin failures++; $display("FAIL single_data got=%h exp=beef", ch_data); end
    checks++; if (mem_address !== 16'h0) begin failures++; $display("FAIL single_excluded_addr got=%h exp=0000", mem_address); end
    ch_rvalid = 4'b0000;
    tick();
    checks++; if (ch_rready !== 4'b0000 || ch_data !== 16'h0) begin failures++; $display("FAIL single_idle got=%b/%h exp=0000/0000", ch_rready, ch_data); end
  endtask

  task automatic test_rotate();
    logic [3:0]  exp_r [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [15:0] exp_d [8] = '{16'hA010, 16'hA020, 16'hA030, 16'hA040, 16'hA010, 16'hA020, 16'hA030, 16'hA040};
    RST = 1'b1;
    preload(16'h0010, 16'hA010);
    preload(16'h0020, 16'hA020);
    preload(16'h0030, 16'hA030);
    preload(16'h0040, 16'hA040);
    quiet_reset();
    ch_address = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    ch_rvalid = 4'b1111;
    #1;
    checks++; if (mem_address !== 16'h0010) begin failures++; $display("FAIL rotate_first_addr got=%h exp=0010", mem_address); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (ch_rready !== exp_r[i]) begin failures++; $display("FAIL rotate_rready[%0d] got=%b exp=%b", i, ch_rready, exp_r[i]); end
      checks++; if (ch_data !== exp_d[i]) begin failures++; $display("FAIL rotate_data[%0d] got=%h exp=%h", i, ch_data, exp_d[i]); end
    end
  endtask

  task automatic test_back_to_back();
    RST = 1'b1;
    preload(16'h0300, 16'h5A5A);
    quiet_reset();
    ch_address[47:32] = 16'h0300;
    ch_rvalid = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (ch_rready !== (i % 2 == 1 ? 4'b0100 : 4'b0000)) begin failures++; $display("FAIL b2b_rready[%0d] got=%b exp=%b", i, ch_rready, (i % 2 == 1 ? 4'b0100 : 4'b0000)); end
      checks++; if (mem_address !== (i % 2 == 1 ? 16'h0000 : 16'h0300)) begin failures++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", i, mem_address, (i % 2 == 1 ? 16'h0000 : 16'h0300)); end
      if (i % 2 == 1) begin
        checks++; if (ch_data !== 16'h5A5A) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=5a5a", i, ch_data); end
      end
      tick();
    end
  endtask

  task automatic test_write_alternation();
    logic       exp_w [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_r [5] = '{4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
    RST = 1'b1;
    preload(16'h0200, 16'h1111);
    quiet_reset();
    wr_address = 16'h0200;
    wr_data = 16'h1234;
    wr_valid = 1'b1;
    ch_address[31:16] = 16'h0200;
    ch_rvalid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (wr_ready !== exp_w[i]) begin failures++; $display("FAIL alt_wr_ready[%0d] got=%b exp=%b", i, wr_ready, exp_w[i]); end
      checks++; if (ch_rready !== exp_r[i]) begin failures++; $display("FAIL alt_rready[%0d] got=%b exp=%b", i, ch_rready, exp_r[i]); end
      if (i == 0) begin
        checks++; if (mem_wr !== 1'b1 || mem_address !== 16'h0200 || mem_wr_data !== 16'h1234) begin failures++; $display("FAIL alt_write_port got=%b/%h/%h exp=1/0200/1234", mem_wr, mem_address, mem_wr_data); end
      end
      if (i == 2) begin
        checks++; if (ch_data !== 16'h1234) begin failures++; $display("FAIL alt_new_data got=%h exp=1234", ch_data); end
      end
      tick();
    end
    wr_valid = 1'b0;
    ch_rvalid = 4'b0000;
  endtask

  task automatic test_reset_midflight();
    RST = 1'b1;
    preload(16'h0400, 16'hC0DE);
    quiet_reset();
    ch_address[63:48] = 16'h0400;
    ch_rvalid = 4'b1000;
    #1;
    checks++; if (mem_address !== 16'h0400) begin failures++; $display("FAIL mid_grant_addr got=%h exp=0400", mem_address); end
    tick();
    RST = 1'b1;
    #1;
    checks++; if (ch_rready !== 4'b0000) begin failures++; $display("FAIL mid_suppressed got=%b exp=0000", ch_rready); end
    tick();
    RST = 1'b0;
    #1;
    checks++; if (ch_rready !== 4'b0000) begin failures++; $display("FAIL mid_after_reset got=%b exp=0000", ch_rready); end
    checks++; if (mem_address !== 16'h0400) begin failures++; $display("FAIL mid_regrant_addr got=%h exp=0400", mem_address); end
    tick();
    checks++; if (ch_rready !== 4'b1000) begin failures++; $display("FAIL mid_rready got=%b exp=1000", ch_rready); end
    checks++; if (ch_data !== 16'hC0DE) begin failures++; $display("FAIL mid_data got=%h exp=c0de", ch_data); end
    ch_rvalid = 4'b0000;
    tick();
  endtask

  initial begin
    RST = 1'b1;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    ch_address = '0;
    ch_rvalid = '0;
    wr_address = '0;
    wr_data = '0;
    wr_valid = 1'b0;
    tick();
    test_reset();
    test_single_read();
    test_rotate();
    test_back_to_back();
    test_write_alternation();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout exceeded 100000 time units");
    $fatal(1);
  end
endmodule
